// File: rtl/ahb_lite_bram_ctrl_if.sv
// AHB-Lite slave-side bus bundle for the BRAM controller.
// The master modport drives the address/data phase, including the HREADY feedback.
interface ahb_lite_bram_ctrl_if;
    logic        HSEL;
    logic [31:0] HADDR;
    logic [1:0]  HTRANS;
    logic        HWRITE;
    logic [2:0]  HSIZE;
    logic [31:0] HWDATA;
    logic        HREADY;
    logic        HREADYOUT;
    logic        HRESP;
    logic [31:0] HRDATA;

    modport master (
        output HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        input  HREADYOUT, HRESP, HRDATA
    );

    modport slave (
        input  HSEL, HADDR, HTRANS, HWRITE, HSIZE, HWDATA, HREADY,
        output HREADYOUT, HRESP, HRDATA
    );
endinterface

// File: rtl/ahb_lite_bram_ctrl.sv
// Zero-wait-state AHB-Lite to single-port BRAM bridge with write-to-read forwarding.
// Define BRAM_CTRL_ERR_EN to enable out-of-range / misalignment ERROR responses.
module ahb_lite_bram_ctrl #(
    parameter int MEMWIDTH  = 8,
    parameter int DATAWIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst_n,
    ahb_lite_bram_ctrl_if.slave  ahb,
    output logic                 mem_wen,
    output logic [MEMWIDTH-1:0]  mem_waddr,
    output logic [MEMWIDTH-1:0]  mem_raddr,
    output logic [DATAWIDTH-1:0] mem_wdata,
    input  logic [DATAWIDTH-1:0] mem_rdata
);
    localparam int LANES = DATAWIDTH / 8;

    localparam logic [2:0] IDLE = 3'd0;
    localparam logic [2:0] RD   = 3'd1;
    localparam logic [2:0] WR   = 3'd2;
`ifdef BRAM_CTRL_ERR_EN
    localparam logic [2:0] ERR1 = 3'd3;
    localparam logic [2:0] ERR2 = 3'd4;
`endif

    logic [2:0]           state_reg, state_next;
    logic [MEMWIDTH-1:0]  word_addr_reg;
    logic [1:0]           byte_off_reg;
    logic [2:0]           size_reg;
    logic                 write_reg;
    logic                 fwd_valid_reg;
    logic [MEMWIDTH-1:0]  fwd_addr_reg;
    logic [DATAWIDTH-1:0] fwd_data_reg;

    logic                 accept;
    logic                 in_rd;
    logic                 in_wr;
    logic [DATAWIDTH-1:0] old_word;
    logic [LANES-1:0]     lane_sel;
    logic                 unused_bits;

    assign accept    = ahb.HSEL & ahb.HREADY & ahb.HTRANS[1];
    // Read address is always presented so the word is ready in the data phase
    assign mem_raddr = ahb.HADDR[MEMWIDTH+1:2];

`ifdef BRAM_CTRL_ERR_EN
    logic addr_err;

    assign addr_err = (|ahb.HADDR[31:MEMWIDTH+2])
                    | ((ahb.HSIZE == 3'd1) & ahb.HADDR[0])
                    | ((ahb.HSIZE == 3'd2) & (ahb.HADDR[1:0] != 2'b00));

    always_comb begin
        state_next = IDLE;
        if (state_reg == ERR1) begin
            state_next = ERR2;
        end else if (accept) begin
            state_next = addr_err ? ERR1 : (ahb.HWRITE ? WR : RD);
        end
    end

    assign ahb.HREADYOUT = (state_reg != ERR1);
    assign ahb.HRESP     = (state_reg == ERR1) | (state_reg == ERR2);
    assign unused_bits   = ahb.HTRANS[0];
`else
    always_comb begin
        state_next = IDLE;
        if (accept) begin
            state_next = ahb.HWRITE ? WR : RD;
        end
    end

    assign ahb.HREADYOUT = 1'b1;
    assign ahb.HRESP     = 1'b0;
    // Upper address bits are dropped so accesses wrap within the BRAM
    assign unused_bits   = ^{ahb.HTRANS[0], ahb.HADDR[31:MEMWIDTH+2]};
`endif

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            word_addr_reg <= '0;
            byte_off_reg  <= '0;
            size_reg      <= '0;
            write_reg     <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (accept) begin
                word_addr_reg <= ahb.HADDR[MEMWIDTH+1:2];
                byte_off_reg  <= ahb.HADDR[1:0];
                size_reg      <= ahb.HSIZE;
                write_reg     <= ahb.HWRITE;
            end
        end
    end

    // The BRAM returns stale data when a word is read in the same cycle it is
    // written; remembering the last write lets the next data phase see it.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fwd_valid_reg <= 1'b0;
            fwd_addr_reg  <= '0;
            fwd_data_reg  <= '0;
        end else begin
            fwd_valid_reg <= mem_wen;
            fwd_addr_reg  <= mem_waddr;
            fwd_data_reg  <= mem_wdata;
        end
    end

    assign in_rd    = (state_reg == RD);
    assign in_wr    = (state_reg == WR);
    assign old_word = (fwd_valid_reg && (fwd_addr_reg == word_addr_reg)) ? fwd_data_reg : mem_rdata;

    assign mem_wen   = in_wr & write_reg;
    assign mem_waddr = word_addr_reg;

    // Sub-word writes are read-modify-write of the whole word
    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            localparam logic [1:0] LANE = 2'(gi);
            assign lane_sel[gi] = (size_reg >= 3'd2)
                                | ((size_reg == 3'd1) & (byte_off_reg[1] == LANE[1]))
                                | ((size_reg == 3'd0) & (byte_off_reg == LANE));
            assign mem_wdata[8*gi +: 8] = lane_sel[gi] ? ahb.HWDATA[8*gi +: 8] : old_word[8*gi +: 8];
        end
    endgenerate

    assign ahb.HRDATA = in_rd ? old_word : '0;
endmodule

// File: tb/tb_ahb_lite_bram_ctrl.sv
// Directed and randomized bench for ahb_lite_bram_ctrl against a word-array reference model.
module tb_ahb_lite_bram_ctrl;
    localparam int MW    = 8;
    localparam int DEPTH = 1 << MW;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    ahb_lite_bram_ctrl_if bus();
    assign bus.HREADY = bus.HREADYOUT;

    logic          mem_wen;
    logic [MW-1:0] mem_waddr, mem_raddr;
    logic [31:0]   mem_wdata, mem_rdata;

    ahb_lite_bram_ctrl #(.MEMWIDTH(MW), .DATAWIDTH(32)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ahb       (bus),
        .mem_wen   (mem_wen),
        .mem_waddr (mem_waddr),
        .mem_raddr (mem_raddr),
        .mem_wdata (mem_wdata),
        .mem_rdata (mem_rdata)
    );

    // BRAM: synchronous write, registered read, read-before-write on collision
    logic [31:0]   bram [DEPTH];
    logic          preload = 1'b0;
    logic [MW-1:0] pre_addr = '0;
    logic [31:0]   pre_data = '0;
    always @(posedge clk) begin
        if (preload) bram[pre_addr] <= pre_data;
        else if (mem_wen) bram[mem_waddr] <= mem_wdata;
        mem_rdata <= bram[mem_raddr];
    end

    logic [31:0] ref_mem [DEPTH];
    int checks = 0;
    int errors = 0;

    logic        pend_valid = 1'b0;
    logic        pend_write = 1'b0;
    logic [31:0] pend_addr  = '0;
    logic [2:0]  pend_size  = '0;
    logic [31:0] pend_wdata = '0;
    logic [31:0] last_rdata = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic int idx(input logic [31:0] addr);
        return int'(addr >> 2) % DEPTH;
    endfunction

    function automatic logic [31:0] merge(input logic [31:0] old, input logic [31:0] wd,
                                          input logic [31:0] addr, input logic [2:0] size);
        logic [31:0] r;
        logic        sel;
        r = old;
        for (int l = 0; l < 4; l++) begin
            case (size)
                3'd0:    sel = (l == int'(addr[1:0]));
                3'd1:    sel = ((l / 2) == int'(addr[1]));
                default: sel = 1'b1;
            endcase
            if (sel) r[8*l +: 8] = wd[8*l +: 8];
        end
        return r;
    endfunction

    task automatic check_data_phase();
        logic [31:0] exp_word;
        chk("hreadyout", bus.HREADYOUT, 32'd1);
        chk("hresp", bus.HRESP, 32'd0);
        chk("mem_wen", mem_wen, pend_valid && pend_write);
        if (pend_valid && !pend_write) begin
            chk("hrdata", bus.HRDATA, ref_mem[idx(pend_addr)]);
            last_rdata = bus.HRDATA;
        end else begin
            chk("hrdata_zero", bus.HRDATA, 32'd0);
        end
        if (pend_valid && pend_write) begin
            exp_word = merge(ref_mem[idx(pend_addr)], pend_wdata, pend_addr, pend_size);
            chk("mem_waddr", mem_waddr, 32'(idx(pend_addr)));
            chk("mem_wdata", mem_wdata, exp_word);
            ref_mem[idx(pend_addr)] = exp_word;
        end
    endtask

    // Drives one address phase while completing the previous transfer's data phase
    task automatic issue(input logic hsel, input logic [1:0] tr, input logic wr,
                         input logic [31:0] addr, input logic [2:0] size, input logic [31:0] wd);
        bus.HSEL   = hsel;
        bus.HTRANS = tr;
        bus.HADDR  = addr;
        bus.HWRITE = wr;
        bus.HSIZE  = size;
        bus.HWDATA = pend_wdata;
        @(negedge clk);
        check_data_phase();
        @(posedge clk);
        #1;
        pend_valid = hsel & tr[1];
        pend_write = wr;
        pend_addr  = addr;
        pend_size  = size;
        pend_wdata = wd;
    endtask

    task automatic idle();
        issue(1'b0, 2'b00, 1'b0, 32'h0, 3'd0, 32'h0);
    endtask

`ifdef BRAM_CTRL_ERR_EN
    task automatic err_xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size);
        issue(1'b1, 2'b10, wr, addr, size, 32'hFFFF_FFFF);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        @(negedge clk);
        chk("err1_hreadyout", bus.HREADYOUT, 32'd0);
        chk("err1_hresp", bus.HRESP, 32'd1);
        chk("err1_mem_wen", mem_wen, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        chk("err2_hreadyout", bus.HREADYOUT, 32'd1);
        chk("err2_hresp", bus.HRESP, 32'd1);
        chk("err2_mem_wen", mem_wen, 32'd0);
        @(posedge clk);
        #1;
        pend_valid = 1'b0;
        pend_wdata = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [31:0] pre_val;
        logic [31:0] a;
        logic [2:0]  sz;

        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HADDR  = '0;
        bus.HWRITE = 1'b0;
        bus.HSIZE  = '0;
        bus.HWDATA = '0;

        preload = 1'b1;
        for (int i = 0; i < DEPTH; i++) begin
            pre_addr   = MW'(i);
            pre_data   = $urandom;
            ref_mem[i] = pre_data;
            @(posedge clk);
            #1;
        end
        preload = 1'b0;

        chk("rst_hreadyout", bus.HREADYOUT, 32'd1);
        chk("rst_hresp", bus.HRESP, 32'd0);
        chk("rst_hrdata", bus.HRDATA, 32'd0);
        chk("rst_mem_wen", mem_wen, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // word write then read back
        issue(1'b1, 2'b10, 1'b1, 32'h10, 3'd2, 32'hDEADBEEF);
        idle();
        issue(1'b1, 2'b10, 1'b0, 32'h10, 3'd2, 32'h0);
        idle();
        chk("wr_rd_0x10", last_rdata, 32'hDEADBEEF);

        // read immediately after write to same word
        issue(1'b1, 2'b10, 1'b1, 32'h20, 3'd2, 32'h11223344);
        issue(1'b1, 2'b11, 1'b0, 32'h20, 3'd2, 32'h0);
        idle();
        chk("fwd_0x20", last_rdata, 32'h11223344);

        // chained sub-word writes
        issue(1'b1, 2'b10, 1'b1, 32'h30, 3'd2, 32'h00000000);
        issue(1'b1, 2'b11, 1'b1, 32'h32, 3'd0, 32'h00AB0000);
        issue(1'b1, 2'b11, 1'b1, 32'h30, 3'd1, 32'h0000CDEF);
        issue(1'b1, 2'b11, 1'b0, 32'h30, 3'd2, 32'h0);
        idle();
        chk("lanes_0x30", last_rdata, 32'h00ABCDEF);

`ifdef BRAM_CTRL_ERR_EN
        pre_val = ref_mem[0];
        err_xfer(1'b1, 32'h0000_0400, 3'd2);
        err_xfer(1'b0, 32'h0000_0002, 3'd2);
        err_xfer(1'b1, 32'h0000_0001, 3'd1);
        issue(1'b1, 2'b10, 1'b0, 32'h0, 3'd2, 32'h0);
        idle();
        chk("err_no_write", last_rdata, pre_val);
`else
        // upper bits wrap, misalignment ignored
        issue(1'b1, 2'b10, 1'b1, 32'h0000_0410, 3'd2, 32'h5A5A1234);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
        idle();
        chk("wrap_0x410", last_rdata, 32'h5A5A1234);
        issue(1'b1, 2'b10, 1'b1, 32'h0000_0011, 3'd2, 32'hA5A5C3C3);
        issue(1'b1, 2'b10, 1'b0, 32'h0000_0010, 3'd2, 32'h0);
        idle();
        chk("misalign_ignored", last_rdata, 32'hA5A5C3C3);
`endif

        // reset during a write data phase
        pre_val = ref_mem[idx(32'h40)];
        issue(1'b1, 2'b10, 1'b1, 32'h40, 3'd2, 32'hCAFEF00D);
        bus.HSEL   = 1'b0;
        bus.HTRANS = 2'b00;
        bus.HWDATA = pend_wdata;
        rst_n = 1'b0;
        #1;
        chk("rstwr_mem_wen", mem_wen, 32'd0);
        chk("rstwr_hrdata", bus.HRDATA, 32'd0);
        @(negedge clk);
        chk("rstwr_mem_wen_hold", mem_wen, 32'd0);
        @(posedge clk);
        #1;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("rstrel_hreadyout", bus.HREADYOUT, 32'd1);
        chk("rstrel_hresp", bus.HRESP, 32'd0);
        pend_valid = 1'b0;
        pend_wdata = '0;
        @(posedge clk);
        #1;
        issue(1'b1, 2'b10, 1'b0, 32'h40, 3'd2, 32'h0);
        idle();
        chk("rst_abandon_write", last_rdata, pre_val);

        // randomized traffic over a few words to provoke collisions
        for (int n = 0; n < 400; n++) begin
            sz = 3'($urandom_range(0, 2));
            a  = 32'h80 + 32'($urandom_range(0, 7) * 4);
            if (sz == 3'd0) a = a + 32'($urandom_range(0, 3));
            else if (sz == 3'd1) a = a + 32'($urandom_range(0, 1) * 2);
            issue(($urandom_range(0, 7) != 0), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                  a, sz, $urandom);
        end
        idle();
        idle();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/ahb_lite_bram_ctrl.md
AHB_LITE_BRAM_CTRL -- requirements
Module: ahb_lite_bram_ctrl

Interface
REQ-001 SHALL have parameter MEMWIDTH, default 8, meaning BRAM word-address width (2**MEMWIDTH words).
REQ-002 SHALL have parameter DATAWIDTH, default 32, meaning BRAM/AHB data width; only 32 is supported.
REQ-003 SHALL have port clk  input  1  the single clock; all logic on posedge.
REQ-004 SHALL have port rst_n  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port HSEL  input  1  slave select.
REQ-006 SHALL have port HADDR  input  32  byte address.
REQ-007 SHALL have port HTRANS  input  2  transfer type; NONSEQ=2, SEQ=3 are active.
REQ-008 SHALL have port HWRITE  input  1  1=write.
REQ-009 SHALL have port HSIZE  input  3  0=byte, 1=half, 2=word.
REQ-010 SHALL have port HWDATA  input  32  write data, valid in data phase.
REQ-011 SHALL have port HREADY  input  1  bus ready.
REQ-012 SHALL have port HREADYOUT  output  1  slave ready.
REQ-013 SHALL have port HRESP  output  1  0=OKAY, 1=ERROR.
REQ-014 SHALL have port HRDATA  output  32  read data.
REQ-015 SHALL have ports mem_wen (output, 1), mem_waddr (output, MEMWIDTH), mem_raddr (output, MEMWIDTH), mem_wdata (output, 32) and mem_rdata (input, 32), driving a BRAM with synchronous write and registered read of 1-cycle latency.

Function
REQ-016 SHALL accept a transfer when HSEL & HREADY & HTRANS[1]=1 and register HADDR[MEMWIDTH+1:2], HADDR[1:0], HSIZE and HWRITE.
REQ-017 SHALL drive mem_raddr=HADDR[MEMWIDTH+1:2] combinationally in every address phase, including writes, so that mem_rdata is valid in the data phase.
REQ-018 SHALL implement states IDLE, RD, WR and ERR1/ERR2; an accepted read goes to RD, an accepted write to WR, and no accepted transfer goes to IDLE.
REQ-019 SHALL complete reads and writes with zero wait states, holding HREADYOUT=1 in IDLE, RD and WR.
REQ-020 In RD, SHALL drive HRDATA=mem_rdata, or fwd_data when fwd_valid and fwd_addr equal the registered word address.
REQ-021 In WR, SHALL assert mem_wen combinationally with mem_waddr set to the registered word address.
REQ-022 In WR, mem_wdata SHALL be the old word (RD-style forwarded/mem_rdata) with only the lanes selected by registered HSIZE/HADDR[1:0] replaced from HWDATA; word writes replace all 4 lanes.
REQ-023 SHALL register fwd_valid=mem_wen, fwd_addr=mem_waddr and fwd_data=mem_wdata every cycle, covering the BRAM read-before-write collision on back-to-back accesses to the same word.
REQ-024 SHALL support back-to-back transfers: an address phase overlapping any data phase is accepted in that same cycle.
REQ-025 HRDATA SHALL be 0 outside RD.
REQ-026 SHALL drive mem_wen=0 outside WR.

Reset
REQ-027 On rst_n=0, SHALL immediately force state=IDLE, HREADYOUT=1, HRESP=0, fwd_valid=0 and all registered address/control to 0.
REQ-028 SHALL abandon any transfer in progress when reset is asserted mid-operation, with no BRAM write after rst_n falls.

Configuration
REQ-029 With BRAM_CTRL_ERR_EN defined, SHALL treat an accepted transfer as an error when HADDR[31:MEMWIDTH+2]!=0, or when it is misaligned (half with HADDR[0]=1, word with HADDR[1:0]!=0).
REQ-030 On such an error, SHALL produce the two-cycle ERROR response (ERR1: HREADYOUT=0, HRESP=1; ERR2: HREADYOUT=1, HRESP=1) with no mem_wen, then return to IDLE.
REQ-031 Without BRAM_CTRL_ERR_EN, SHALL tie HRESP=0, ignore upper address bits (wrap modulo 2**MEMWIDTH words), ignore misalignment, and omit ERR1/ERR2.

Verification
REQ-032 Word write 0xDEADBEEF to 0x10, then read 0x10 -> HRDATA=0xDEADBEEF, with zero wait states on both transfers.
REQ-033 Back-to-back write 0x11223344 @0x20 followed immediately by a read @0x20 -> read returns 0x11223344 via forwarding.
REQ-034 Word 0x00000000 @0x30, then byte write 0xAB on lane 2 @0x32, then half write 0xCDEF @0x30, all back-to-back, then read -> 0x00ABCDEF.
REQ-035 BRAM_CTRL_ERR_EN defined, write to 0x0000_0400 -> HREADYOUT=0/HRESP=1 for one cycle, then 1/1, mem_wen never asserted; word read @0x02 also errors.
REQ-036 rst_n pulsed low during a WR data phase -> mem_wen=0 during reset, HREADYOUT=1, HRESP=0 on release, and the next read of that word returns its pre-write value.
